fp16div: RTL and testbench
==========================

# fp16div

Sequential IEEE-754 half-precision divider; the inverse operation to the team's fp16 multiplier, with the same operand packing and the same exponent and significand conventions. It computes x = a / b using restoring radix-2 division of the 11-bit significands, one quotient bit per cycle, then rounds to nearest-even. Valid/ready handshakes on both sides let it sit in the same datapath slot as the multiplier.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- a  in  16  dividend, fp16 (sign[15], exp[14:10], frac[9:0]).
- b  in  16  divisor, fp16.
- in_valid  in  1  operands valid.
- in_ready  out  1  block idle and accepting; high only in IDLE.
- x  out  16  quotient, fp16, registered.
- out_valid  out  1  x valid; held until consumed.
- out_ready  in  1  consumer accepts x.

## Operation
- States: IDLE, DIVIDE, ROUND, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid: capture the operands.
  - Set sign = a[15]^b[15], ma = {1,a[9:0]}, mb = {1,b[9:0]}, rem = ma, cnt = 0.
  - Go to DIVIDE.
- DIVIDE (13 cycles, cnt 0..12)
  - If rem >= mb: shift in q bit 1 and set rem = (rem-mb)<<1.
  - Else: shift in q bit 0 and set rem = rem<<1.
  - rem is 12 bits. Q is 13 bits and ends as floor(ma·2^12/mb), within (2048, 8192).
  - After cnt = 12, go to ROUND.
- ROUND
  - e = ea − eb + 15, computed as 7-bit signed.
  - If Q[12] = 1: mant = Q[11:2], g = Q[1], s = Q[0] | (rem≠0).
  - If Q[12] = 0: mant = Q[10:1], g = Q[0], s = (rem≠0), e = e − 1.
  - Round up when g & (s | mant[0]). If the mantissa carries out: mant = 0, e = e + 1.
  - Load x = {sign, e[4:0], mant}. Set out_valid = 1. Go to DONE.
- DONE
  - x and out_valid are held stable.
  - When out_ready is high: clear out_valid and go to IDLE.
- Hidden bits are always forced to 1, so b = 0 never divides by zero internally.
- Inputs are sampled only at accept. a, b and in_valid are ignored outside IDLE.

## Timing
- Reset values: state = IDLE, x = 16'h0000, out_valid = 0. in_ready = 1 once reset deasserts.
- Accept edge k → out_valid rises after edge k+14. That is 13 DIVIDE edges plus 1 ROUND edge.
- The handshake completes on the edge where out_valid & out_ready. in_ready is high in the following cycle.
- Minimum throughput: one operation per 16 cycles. Operations never overlap.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- Asserting rst mid-operation aborts immediately: IDLE, out_valid = 0, x = 0. The partial result is discarded.
- Latency is fixed, including for special-case results.

## Configuration
- Macro: FP16DIV_SPECIAL_EN.
- Undefined
  - No special-case handling.
  - Exponent fields are treated as plain biased values; e[4:0] wraps on overflow or underflow.
  - Subnormals are treated as normals with the hidden bit set.
- Defined (evaluated in ROUND, in priority order)
  1. a or b is NaN, or 0/0, or ∞/∞ → 16'h7E00.
  2. a is ∞ or b is zero → {sign, 5'h1F, 10'h0}.
  3. a is zero or b is ∞ → {sign, 15'h0}.
  4. e ≥ 31 → signed ∞.
  5. e ≤ 0 → signed zero.
  - Subnormal inputs (exp = 0) count as zero.

## Test plan
- 16'h3C00 / 16'h3C00 → x = 16'h3C00. out_valid high exactly 14 edges after the accept edge. in_ready low throughout.
- 16'h4200 / 16'h4000 (3/2) → 16'h3E00. 16'h3C00 / 16'h4200 (1/3) → 16'h3555; this case exercises the Q[12] = 0 normalization path.
- Backpressure: hold out_ready low for 5 cycles after out_valid.
  - x and out_valid stay stable and in_ready stays 0.
  - A second in_valid pulse during this time is ignored.
  - Raise out_ready → in_ready is 1 on the next cycle.
- Without the macro: 16'h3C00 / 16'h0000 → 16'h7800.
- With the macro:
  - 16'h3C00 / 16'h0000 → 16'h7C00.
  - 16'h0000 / 16'h0000 → 16'h7E00.
  - 16'hBC00 / 16'h7C00 → 16'h8000.
  - 16'h7800 / 16'h0400 → 16'h7C00 (overflow).
- Assert rst 6 cycles after an accept → out_valid = 0 and x = 0 immediately. Deassert rst, then issue 16'h4000 / 16'h3C00 → 16'h4000 with normal latency.

Source files
------------

// File: rtl/fp16div_if.sv
// Valid/ready operand and result handshake bundle for the fp16 divider.
interface fp16div_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, x, out_valid
    );

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, x, out_valid
    );
endinterface

// File: rtl/fp16div.sv
// Sequential fp16 divider: restoring radix-2 significand division, one quotient bit per cycle, round-to-nearest-even.
// Optional IEEE special-case handling (NaN/inf/zero, overflow/underflow) is enabled by defining FP16DIV_SPECIAL_EN.
module fp16div (
    input  logic         clk,
    input  logic         rst,
    fp16div_if.slave     bus
);

`ifdef FP16DIV_SPECIAL_EN
    localparam int EW = 7;
`else
    localparam int EW = 5;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;

    logic          r_sign;
    logic [4:0]    r_ea;
    logic [4:0]    r_eb;
    logic [10:0]   r_mb;
    logic [11:0]   r_rem;
    logic [12:0]   r_q;
    logic [3:0]    r_cnt;
    logic [15:0]   r_x;
    logic          r_out_valid;

    logic          w_rem_ge;
    logic [11:0]   w_rem_diff;

    logic [EW-1:0] w_e_base;
    logic [EW-1:0] w_e_norm;
    logic [EW-1:0] w_e_fin;
    logic [9:0]    w_mant_tr;
    logic [9:0]    w_mant_fin;
    logic [10:0]   w_mant_inc;
    logic          w_g;
    logic          w_s;
    logic          w_rnd_up;
    logic [15:0]   w_x_round;

`ifdef FP16DIV_SPECIAL_EN
    logic          r_a_nan;
    logic          r_a_inf;
    logic          r_a_zero;
    logic          r_b_nan;
    logic          r_b_inf;
    logic          r_b_zero;

    // Subnormals (exp = 0) are classified as zero.
    function automatic logic f_is_nan(input logic [15:0] v);
        f_is_nan = (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

    function automatic logic f_is_inf(input logic [15:0] v);
        f_is_inf = (v[14:10] == 5'h1F) && (v[9:0] == 10'h000);
    endfunction

    function automatic logic f_is_zero(input logic [15:0] v);
        f_is_zero = (v[14:10] == 5'h00);
    endfunction
`endif

    assign w_rem_ge   = (r_rem >= {1'b0, r_mb});
    assign w_rem_diff = r_rem - {1'b0, r_mb};

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.x         = r_x;
    assign bus.out_valid = r_out_valid;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nx = S_DIVIDE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (r_cnt == 4'd12) begin
                    w_state_nx = S_ROUND;
                end else begin
                    w_state_nx = S_DIVIDE;
                end
            end
            S_ROUND: begin
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Normalisation and round-to-nearest-even of the finished quotient.
    always_comb begin
        w_e_base   = EW'(r_ea) - EW'(r_eb) + EW'(15);
        w_e_norm   = w_e_base;
        w_mant_tr  = 10'h000;
        w_g        = 1'b0;
        w_s        = 1'b0;
        if (r_q[12]) begin
            w_mant_tr = r_q[11:2];
            w_g       = r_q[1];
            w_s       = r_q[0] | (r_rem != 12'h000);
            w_e_norm  = w_e_base;
        end else begin
            w_mant_tr = r_q[10:1];
            w_g       = r_q[0];
            w_s       = (r_rem != 12'h000);
            w_e_norm  = w_e_base - EW'(1);
        end
        w_rnd_up   = w_g & (w_s | w_mant_tr[0]);
        w_mant_inc = {1'b0, w_mant_tr} + {10'h000, w_rnd_up};
        // A carry out leaves the low ten bits at zero, which is the renormalised mantissa.
        w_mant_fin = w_mant_inc[9:0];
        if (w_mant_inc[10]) begin
            w_e_fin = w_e_norm + EW'(1);
        end else begin
            w_e_fin = w_e_norm;
        end
    end

    // Result selection, with special cases in priority order when enabled.
    always_comb begin
        w_x_round = {r_sign, w_e_fin[4:0], w_mant_fin};
`ifdef FP16DIV_SPECIAL_EN
        if (r_a_nan || r_b_nan || (r_a_zero && r_b_zero) || (r_a_inf && r_b_inf)) begin
            w_x_round = 16'h7E00;
        end else if (r_a_inf || r_b_zero) begin
            w_x_round = {r_sign, 5'h1F, 10'h000};
        end else if (r_a_zero || r_b_inf) begin
            w_x_round = {r_sign, 15'h0000};
        end else if ($signed(w_e_fin) >= 7'sd31) begin
            w_x_round = {r_sign, 5'h1F, 10'h000};
        end else if ($signed(w_e_fin) <= 7'sd0) begin
            w_x_round = {r_sign, 15'h0000};
        end else begin
            w_x_round = {r_sign, w_e_fin[4:0], w_mant_fin};
        end
`endif
    end

    // Operand capture, restoring division iterations and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign      <= 1'b0;
            r_ea        <= 5'h00;
            r_eb        <= 5'h00;
            r_mb        <= 11'h000;
            r_rem       <= 12'h000;
            r_q         <= 13'h0000;
            r_cnt       <= 4'd0;
            r_x         <= 16'h0000;
            r_out_valid <= 1'b0;
`ifdef FP16DIV_SPECIAL_EN
            r_a_nan     <= 1'b0;
            r_a_inf     <= 1'b0;
            r_a_zero    <= 1'b0;
            r_b_nan     <= 1'b0;
            r_b_inf     <= 1'b0;
            r_b_zero    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign   <= bus.a[15] ^ bus.b[15];
                        r_ea     <= bus.a[14:10];
                        r_eb     <= bus.b[14:10];
                        r_mb     <= {1'b1, bus.b[9:0]};
                        r_rem    <= {2'b01, bus.a[9:0]};
                        r_q      <= 13'h0000;
                        r_cnt    <= 4'd0;
`ifdef FP16DIV_SPECIAL_EN
                        r_a_nan  <= f_is_nan(bus.a);
                        r_a_inf  <= f_is_inf(bus.a);
                        r_a_zero <= f_is_zero(bus.a);
                        r_b_nan  <= f_is_nan(bus.b);
                        r_b_inf  <= f_is_inf(bus.b);
                        r_b_zero <= f_is_zero(bus.b);
`endif
                    end
                end
                S_DIVIDE: begin
                    // rem stays below 2*mb, so the shifted value always fits 12 bits.
                    if (w_rem_ge) begin
                        r_rem <= w_rem_diff << 1;
                        r_q   <= {r_q[11:0], 1'b1};
                    end else begin
                        r_rem <= r_rem << 1;
                        r_q   <= {r_q[11:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                S_ROUND: begin
                    r_x         <= w_x_round;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16div.sv
// Self-checking bench for fp16div: directed cases, handshake/latency checks and randomized operands against a reference model.
module tb_fp16div;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp16div_if bus ();

    fp16div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference quotient from exact integer division of the significands.
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int   ma, mb, num, q, r, e, mant, g, s;
        logic sg;
        sg   = a[15] ^ b[15];
        ma   = 1024 + int'(a[9:0]);
        mb   = 1024 + int'(b[9:0]);
        num  = ma * 4096;
        q    = num / mb;
        r    = num % mb;
        e    = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (q >= 4096) begin
            mant = (q / 4) % 1024;
            g    = (q / 2) % 2;
            s    = ((q % 2) != 0 || r != 0) ? 1 : 0;
        end else begin
            mant = (q / 2) % 1024;
            g    = q % 2;
            s    = (r != 0) ? 1 : 0;
            e    = e - 1;
        end
        if (g == 1 && (s == 1 || (mant % 2) == 1)) mant = mant + 1;
        if (mant == 1024) begin
            mant = 0;
            e    = e + 1;
        end
`ifdef FP16DIV_SPECIAL_EN
        begin
            bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
            a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
            b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
            a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
            b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
            a_zero = (a[14:10] == 5'd0);
            b_zero = (b[14:10] == 5'd0);
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 16'h7E00;
            if (a_inf || b_zero) return {sg, 15'h7C00};
            if (a_zero || b_inf) return {sg, 15'h0000};
            if (e >= 31) return {sg, 15'h7C00};
            if (e <= 0) return {sg, 15'h0000};
        end
`endif
        return {sg, 5'(e & 31), 10'(mant)};
    endfunction

    // One full transaction: accept, latency/busy checks, optional backpressure, handshake.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input string tag,
                          input bit early_ready, input int hold, input bit poke,
                          output logic [15:0] got);
        int lat;
        int busy_bad;
        int unstable;
        check_eq({tag, "/in_ready_idle"}, 16'(bus.in_ready), 16'd1);
        bus.a         = ta;
        bus.b         = tb_v;
        bus.in_valid  = 1'b1;
        bus.out_ready = early_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        lat      = 0;
        busy_bad = 0;
        do begin
            if (bus.in_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 40);
        check_eq({tag, "/latency"}, 16'(lat), 16'd14);
        check_eq({tag, "/busy_in_ready"}, 16'(busy_bad), 16'd0);
        got = bus.x;
        if (!early_ready) begin
            unstable = 0;
            for (int i = 0; i < hold; i++) begin
                if (poke && i == 1) begin
                    bus.a        = 16'h4400;
                    bus.b        = 16'h3C00;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
                @(posedge clk); #1;
                if (bus.x !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable++;
            end
            bus.in_valid = 1'b0;
            check_eq({tag, "/hold_stable"}, 16'(unstable), 16'd0);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq({tag, "/out_valid_clr"}, 16'(bus.out_valid), 16'd0);
        check_eq({tag, "/in_ready_after"}, 16'(bus.in_ready), 16'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        logic [15:0] ra, rb;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset/x", bus.x, 16'h0000);
        check_eq("reset/out_valid", 16'(bus.out_valid), 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset/in_ready", 16'(bus.in_ready), 16'd1);

        run_op(16'h3C00, 16'h3C00, "one_div_one", 1'b0, 0, 1'b0, got);
        check_eq("one_div_one/x", got, 16'h3C00);
        run_op(16'h4200, 16'h4000, "three_halves", 1'b1, 0, 1'b0, got);
        check_eq("three_halves/x", got, 16'h3E00);
        run_op(16'h3C00, 16'h4200, "one_third", 1'b0, 0, 1'b0, got);
        check_eq("one_third/x", got, 16'h3555);
        run_op(16'h4200, 16'h4000, "backpressure", 1'b0, 5, 1'b1, got);
        check_eq("backpressure/x", got, 16'h3E00);

`ifdef FP16DIV_SPECIAL_EN
        run_op(16'h3C00, 16'h0000, "div_zero", 1'b1, 0, 1'b0, got);
        check_eq("div_zero/x", got, 16'h7C00);
        run_op(16'h0000, 16'h0000, "zero_zero", 1'b1, 0, 1'b0, got);
        check_eq("zero_zero/x", got, 16'h7E00);
        run_op(16'hBC00, 16'h7C00, "neg_div_inf", 1'b1, 0, 1'b0, got);
        check_eq("neg_div_inf/x", got, 16'h8000);
        run_op(16'h7800, 16'h0400, "overflow", 1'b1, 0, 1'b0, got);
        check_eq("overflow/x", got, 16'h7C00);
`else
        run_op(16'h3C00, 16'h0000, "div_zero_plain", 1'b1, 0, 1'b0, got);
        check_eq("div_zero_plain/x", got, 16'h7800);
`endif

        // Abort mid-operation via asynchronous reset.
        run_op(16'h4200, 16'h4000, "pre_abort", 1'b1, 0, 1'b0, got);
        bus.a        = 16'h3C00;
        bus.b        = 16'h4200;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("abort/out_valid", 16'(bus.out_valid), 16'd0);
        check_eq("abort/x", bus.x, 16'h0000);
        check_eq("abort/in_ready", 16'(bus.in_ready), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(16'h4000, 16'h3C00, "after_abort", 1'b0, 0, 1'b0, got);
        check_eq("after_abort/x", got, 16'h4000);

        for (int n = 0; n < 150; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, "rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), got);
            check_eq("rand/x", got, ref_div(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
